// File: rtl/net_pkt_gen_pkg.sv
// Shared types, constants and helpers for the packet generator and its
// receive-side companions.
package net_pkg;

  localparam int NET_DATA_W  = 512;
  localparam int NET_BYTES   = NET_DATA_W / 8;
  localparam int NET_LEN_W   = 16;
  localparam int HDR_DST_LSB = 176;
  localparam int HDR_SEQ_LSB = 0;

  typedef struct packed {
    logic                  last;
    logic [NET_DATA_W-1:0] data;
    logic [NET_BYTES-1:0]  keep;
  } net_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } net_state_t;

  // One extra bit so that a 0xFFFF-byte packet does not wrap the beat count.
  function automatic logic [NET_LEN_W:0] nbeats(input logic [NET_LEN_W-1:0] len);
    return ({1'b0, len} + (NET_LEN_W + 1)'(63)) >> 6;
  endfunction

endpackage

// File: rtl/net_pkt_gen_if.sv
// Command and beat-stream handshake bundle between the packet generator
// and whatever drives/consumes it.
interface net_pkt_gen_if #(
  parameter int DATA_W = 512,
  parameter int LEN_W  = 16,
  parameter int DST_W  = 16
);

  logic                  io_cmd_valid;
  logic                  io_cmd_ready;
  logic [DST_W-1:0]      io_cmd_bits_dst;
  logic [LEN_W-1:0]      io_cmd_bits_len;

  logic                  io_out_valid;
  logic                  io_out_ready;
  logic                  io_out_bits_last;
  logic [DATA_W-1:0]     io_out_bits_data;
  logic [DATA_W/8-1:0]   io_out_bits_keep;

  modport master (
    input  io_cmd_valid, io_cmd_bits_dst, io_cmd_bits_len, io_out_ready,
    output io_cmd_ready, io_out_valid, io_out_bits_last, io_out_bits_data,
           io_out_bits_keep
  );

  modport slave (
    output io_cmd_valid, io_cmd_bits_dst, io_cmd_bits_len, io_out_ready,
    input  io_cmd_ready, io_out_valid, io_out_bits_last, io_out_bits_data,
           io_out_bits_keep
  );

endinterface

// File: rtl/net_keep_gen.sv
// Tail byte-enable mask: remM1 = (bytes in final beat) - 1, low remM1+1
// bits of keep are set.
module net_keep_gen
  import net_pkg::*;
(
  input  logic [5:0]           remM1,
  output logic [NET_BYTES-1:0] keep
);

  always_comb begin
    keep = '0;
    for (int i = 0; i < NET_BYTES; i++) begin
      keep[i] = (6'(i) <= remM1);
    end
  end

endmodule

// File: rtl/net_pkt_gen.sv
// Descriptor-driven packet source: header beat then pattern payload beats,
// with a registered output stage that holds steady under backpressure.
module net_pkt_gen
  import net_pkg::*;
#(
  parameter int DATA_W = NET_DATA_W,
  parameter int LEN_W  = NET_LEN_W,
  parameter int DST_W  = 16
) (
  input  logic          clock,
  input  logic          reset,
  net_pkt_gen_if.master bus,
  output logic          io_busy,
  output logic [31:0]   io_pkt_count,
  output logic          io_err
);

  localparam int IDX_W = LEN_W - 6 + 1;

  net_state_t           state, stateNxt;
  logic [31:0]          seq, pktCount, seqNew;
  logic [DST_W-1:0]     dstQ;
  logic [LEN_W:0]       nBeatsQ;
  logic [5:0]           remM1Q, remSel;
  logic [IDX_W-1:0]     beatIdx, beatIdxNxt;
  logic [NET_BYTES-1:0] tailKeep;
  net_beat_t            beat_p1, beatNxt;
  logic                 vld_p1, vldNxt, err_p1;
  logic                 fire, lastFire, cmdReady, cmdFire, loadCmd, zeroCmd;

  function automatic net_beat_t buildBeat(
    input logic [DST_W-1:0]     dst,
    input logic [31:0]          seqV,
    input logic [IDX_W-1:0]     idx,
    input logic [LEN_W:0]       nb,
    input logic [NET_BYTES-1:0] tail
  );
    net_beat_t b;
    b.last = ({{(LEN_W + 1 - IDX_W){1'b0}}, idx} == nb - (LEN_W + 1)'(1));
    b.keep = b.last ? tail : '1;
    b.data = '0;
    if (idx == '0) begin
      b.data[HDR_DST_LSB +: DST_W] = dst;
      b.data[HDR_SEQ_LSB +: 32]    = seqV;
    end else begin
      b.data = {16{seqV[15:0], 16'(idx)}};
    end
    return b;
  endfunction

  always_comb begin
    fire     = vld_p1 && bus.io_out_ready;
    lastFire = fire && beat_p1.last;
    cmdReady = (state == IDLE) || lastFire;
    cmdFire  = bus.io_cmd_valid && cmdReady;
    loadCmd  = cmdFire && (bus.io_cmd_bits_len != '0);
    zeroCmd  = cmdFire && (bus.io_cmd_bits_len == '0);
    // A packet queued behind a completing one already carries the bumped seq.
    seqNew   = lastFire ? seq + 32'd1 : seq;
    remSel   = loadCmd ? bus.io_cmd_bits_len[5:0] - 6'd1 : remM1Q;
  end

  net_keep_gen u_keep (
    .remM1 (remSel),
    .keep  (tailKeep)
  );

  always_comb begin
    stateNxt   = state;
    vldNxt     = vld_p1;
    beatNxt    = beat_p1;
    beatIdxNxt = beatIdx;
    case (state)
      IDLE: if (loadCmd) stateNxt = SEND;
      SEND: if (lastFire) stateNxt = loadCmd ? SEND : IDLE;
    endcase
    if (loadCmd) begin
      vldNxt     = 1'b1;
      beatIdxNxt = '0;
      beatNxt    = buildBeat(bus.io_cmd_bits_dst, seqNew, '0,
                             nbeats(bus.io_cmd_bits_len), tailKeep);
    end else if (lastFire) begin
      vldNxt       = 1'b0;
      beatNxt.last = 1'b0;
    end else if (fire) begin
      beatIdxNxt = beatIdx + IDX_W'(1);
      beatNxt    = buildBeat(dstQ, seq, beatIdx + IDX_W'(1), nBeatsQ, tailKeep);
    end
  end

  // Stage p1: registered beat and control
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      vld_p1   <= 1'b0;
      beat_p1  <= '0;
      beatIdx  <= '0;
      seq      <= '0;
      pktCount <= '0;
      err_p1   <= 1'b0;
    end else begin
      state    <= stateNxt;
      vld_p1   <= vldNxt;
      beat_p1  <= beatNxt;
      beatIdx  <= beatIdxNxt;
      err_p1   <= zeroCmd;
      if (lastFire) begin
        seq      <= seq + 32'd1;
        pktCount <= pktCount + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (loadCmd) begin
      dstQ    <= bus.io_cmd_bits_dst;
      nBeatsQ <= nbeats(bus.io_cmd_bits_len);
      remM1Q  <= bus.io_cmd_bits_len[5:0] - 6'd1;
    end
  end

  assign bus.io_cmd_ready     = cmdReady;
  assign bus.io_out_valid     = vld_p1;
  assign bus.io_out_bits_last = beat_p1.last;
  assign bus.io_out_bits_data = DATA_W'(beat_p1.data);
  assign bus.io_out_bits_keep = beat_p1.keep;
  assign io_busy              = (state == SEND);
  assign io_pkt_count         = pktCount;
  assign io_err               = err_p1;

endmodule

// File: tb/tb_net_pkt_gen.sv
// Directed bench for net_pkt_gen: framing, keep, backpressure, chaining,
// zero-length drop and mid-packet reset.
module tb_net_pkt_gen;
  import net_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pktCount;
  logic        busy, err;

  net_pkt_gen_if #(.DATA_W(512), .LEN_W(16), .DST_W(16)) bus ();

  net_pkt_gen dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .io_busy      (busy),
    .io_pkt_count (pktCount),
    .io_err       (err)
  );

  always #5 clock = ~clock;

  int        tests = 0, fails = 0, cycle = 0, validCycles = 0;
  net_beat_t beatQ[$];
  int        beatCyc[$];
  net_beat_t mb;

  always @(posedge clock) cycle <= cycle + 1;

  always @(negedge clock) begin
    if (bus.io_out_valid) validCycles++;
    if (bus.io_out_valid && bus.io_out_ready) begin
      mb.last = bus.io_out_bits_last;
      mb.data = bus.io_out_bits_data;
      mb.keep = bus.io_out_bits_keep;
      beatQ.push_back(mb);
      beatCyc.push_back(cycle);
    end
  end

  function automatic logic [511:0] hdrData(input logic [15:0] dst, input logic [31:0] s);
    logic [511:0] d;
    d = '0;
    d[511:176] = {320'd0, dst};
    d[175:0]   = {144'd0, s};
    return d;
  endfunction

  function automatic logic [511:0] payData(input logic [31:0] s, input int k);
    logic [31:0] w;
    w = {s[15:0], 16'(k)};
    return {16{w}};
  endfunction

  task automatic sendCmd(input logic [15:0] dst, input logic [15:0] len);
    bit done;
    done = 0;
    bus.io_cmd_valid    = 1'b1;
    bus.io_cmd_bits_dst = dst;
    bus.io_cmd_bits_len = len;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (bus.io_cmd_ready) done = 1;
      @(posedge clock); #1;
    end
    bus.io_cmd_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL cmd_timeout: ready=0 required=1 (dst=%0d len=%0d)", dst, len);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    @(negedge clock);
    tests++; if (bus.io_out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.io_out_valid); end
    tests++; if (bus.io_out_bits_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", bus.io_out_bits_last); end
    tests++; if (bus.io_out_bits_data !== 512'd0) begin fails++; $display("FAIL rst_data: got %h want 0", bus.io_out_bits_data); end
    tests++; if (bus.io_out_bits_keep !== 64'd0) begin fails++; $display("FAIL rst_keep: got %h want 0", bus.io_out_bits_keep); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (pktCount !== 32'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", pktCount); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    tests++; if (bus.io_cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_cmd_ready: got %b want 1", bus.io_cmd_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_single;
    beatQ.delete(); beatCyc.delete();
    bus.io_out_ready = 1'b1;
    sendCmd(16'd2, 16'd64);
    @(negedge clock);
    tests++; if (bus.io_out_valid !== 1'b1) begin fails++; $display("FAIL hdr_latency: valid=%b want 1", bus.io_out_valid); end
    @(posedge clock); #1;
    idle(3);
    tests++;
    if (beatQ.size() != 1) begin
      fails++; $display("FAIL single_beats: got %0d want 1", beatQ.size());
    end else begin
      tests++; if (beatQ[0].last !== 1'b1) begin fails++; $display("FAIL single_last: got %b want 1", beatQ[0].last); end
      tests++; if (beatQ[0].keep !== 64'hffff_ffff_ffff_ffff) begin fails++; $display("FAIL single_keep: got %h want all ones", beatQ[0].keep); end
      tests++; if (beatQ[0].data !== hdrData(16'd2, 32'd0)) begin fails++; $display("FAIL single_hdr: got %h want %h", beatQ[0].data, hdrData(16'd2, 32'd0)); end
    end
    tests++; if (pktCount !== 32'd1) begin fails++; $display("FAIL single_count: got %0d want 1", pktCount); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_multi;
    logic [63:0]  expKeep;
    logic [511:0] expData;
    beatQ.delete(); beatCyc.delete();
    bus.io_out_ready = 1'b1;
    sendCmd(16'd3, 16'd130);
    idle(6);
    tests++;
    if (beatQ.size() != 3) begin
      fails++; $display("FAIL multi_beats: got %0d want 3", beatQ.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        expKeep = (i == 2) ? 64'h3 : '1;
        expData = (i == 0) ? hdrData(16'd3, 32'd1) : payData(32'd1, i);
        tests++; if (beatQ[i].last !== (i == 2)) begin fails++; $display("FAIL multi_last[%0d]: got %b want %b", i, beatQ[i].last, (i == 2)); end
        tests++; if (beatQ[i].keep !== expKeep) begin fails++; $display("FAIL multi_keep[%0d]: got %h want %h", i, beatQ[i].keep, expKeep); end
        tests++; if (beatQ[i].data !== expData) begin fails++; $display("FAIL multi_data[%0d]: got %h want %h", i, beatQ[i].data, expData); end
      end
      tests++; if (beatQ[1].data !== {16{16'h0001, 16'h0001}}) begin fails++; $display("FAIL multi_beat1_literal: got %h", beatQ[1].data); end
    end
    tests++; if (pktCount !== 32'd2) begin fails++; $display("FAIL multi_count: got %0d want 2", pktCount); end
  endtask

  task automatic test_backpressure;
    bit           pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit           prevStall;
    logic [511:0] prevData;
    logic [63:0]  prevKeep;
    logic         prevLast;
    beatQ.delete(); beatCyc.delete();
    prevStall = 0;
    prevData = '0; prevKeep = '0; prevLast = 1'b0;
    bus.io_out_ready = 1'b0;
    sendCmd(16'd4, 16'd200);
    for (int c = 0; c < 40; c++) begin
      bus.io_out_ready = pat[c % 4];
      @(negedge clock);
      if (prevStall) begin
        tests++;
        if (bus.io_out_valid !== 1'b1 || bus.io_out_bits_data !== prevData ||
            bus.io_out_bits_keep !== prevKeep || bus.io_out_bits_last !== prevLast) begin
          fails++;
          $display("FAIL bp_hold c=%0d: valid=%b last=%b keep=%h want valid=1 last=%b keep=%h",
                   c, bus.io_out_valid, bus.io_out_bits_last, bus.io_out_bits_keep, prevLast, prevKeep);
        end
      end
      prevStall = bus.io_out_valid && !bus.io_out_ready;
      prevData  = bus.io_out_bits_data;
      prevKeep  = bus.io_out_bits_keep;
      prevLast  = bus.io_out_bits_last;
      @(posedge clock); #1;
    end
    bus.io_out_ready = 1'b1;
    tests++;
    if (beatQ.size() != 4) begin
      fails++; $display("FAIL bp_beats: got %0d want 4", beatQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (beatQ[i].last !== (i == 3)) begin fails++; $display("FAIL bp_last[%0d]: got %b want %b", i, beatQ[i].last, (i == 3)); end
      end
      tests++; if (beatQ[3].keep !== 64'hff) begin fails++; $display("FAIL bp_keep: got %h want ff", beatQ[3].keep); end
      tests++; if (beatQ[0].data !== hdrData(16'd4, 32'd2)) begin fails++; $display("FAIL bp_hdr: got %h", beatQ[0].data); end
      tests++; if (beatQ[3].data !== payData(32'd2, 3)) begin fails++; $display("FAIL bp_pay3: got %h want %h", beatQ[3].data, payData(32'd2, 3)); end
    end
    tests++; if (pktCount !== 32'd3) begin fails++; $display("FAIL bp_count: got %0d want 3", pktCount); end
  endtask

  task automatic test_back_to_back;
    beatQ.delete(); beatCyc.delete();
    bus.io_out_ready = 1'b1;
    sendCmd(16'd5, 16'd65);
    sendCmd(16'd6, 16'd1);
    idle(5);
    tests++;
    if (beatQ.size() != 3) begin
      fails++; $display("FAIL b2b_beats: got %0d want 3", beatQ.size());
    end else begin
      tests++; if (beatQ[0].last !== 1'b0 || beatQ[0].keep !== '1 || beatQ[0].data !== hdrData(16'd5, 32'd3)) begin
        fails++; $display("FAIL b2b_hdr0: last=%b keep=%h data=%h", beatQ[0].last, beatQ[0].keep, beatQ[0].data); end
      tests++; if (beatQ[1].last !== 1'b1 || beatQ[1].keep !== 64'h1 || beatQ[1].data !== payData(32'd3, 1)) begin
        fails++; $display("FAIL b2b_tail0: last=%b keep=%h data=%h", beatQ[1].last, beatQ[1].keep, beatQ[1].data); end
      tests++; if (beatQ[2].last !== 1'b1 || beatQ[2].keep !== 64'h1 || beatQ[2].data !== hdrData(16'd6, 32'd4)) begin
        fails++; $display("FAIL b2b_hdr1: last=%b keep=%h data=%h", beatQ[2].last, beatQ[2].keep, beatQ[2].data); end
      tests++; if (beatCyc[1] != beatCyc[0] + 1 || beatCyc[2] != beatCyc[1] + 1) begin
        fails++; $display("FAIL b2b_bubble: cycles %0d %0d %0d want consecutive", beatCyc[0], beatCyc[1], beatCyc[2]); end
    end
    tests++; if (pktCount !== 32'd5) begin fails++; $display("FAIL b2b_count: got %0d want 5", pktCount); end
  endtask

  task automatic test_zero_len;
    beatQ.delete(); beatCyc.delete();
    bus.io_out_ready = 1'b1;
    validCycles = 0;
    sendCmd(16'd7, 16'd0);
    @(negedge clock);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL zero_err_pulse: got %b want 1", err); end
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL zero_err_width: got %b want 0", err); end
    @(posedge clock); #1;
    idle(3);
    tests++; if (validCycles != 0) begin fails++; $display("FAIL zero_valid: got %0d valid cycles want 0", validCycles); end
    tests++; if (pktCount !== 32'd5) begin fails++; $display("FAIL zero_count: got %0d want 5", pktCount); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b want 0", busy); end
    sendCmd(16'd8, 16'd10);
    idle(4);
    tests++;
    if (beatQ.size() != 1) begin
      fails++; $display("FAIL zero_next_beats: got %0d want 1", beatQ.size());
    end else begin
      tests++; if (beatQ[0].last !== 1'b1 || beatQ[0].keep !== 64'h3ff || beatQ[0].data !== hdrData(16'd8, 32'd5)) begin
        fails++; $display("FAIL zero_next_beat: last=%b keep=%h data=%h", beatQ[0].last, beatQ[0].keep, beatQ[0].data); end
    end
    tests++; if (pktCount !== 32'd6) begin fails++; $display("FAIL zero_next_count: got %0d want 6", pktCount); end
  endtask

  task automatic test_reset_mid;
    beatQ.delete(); beatCyc.delete();
    bus.io_out_ready = 1'b1;
    sendCmd(16'd9, 16'd130);
    @(posedge clock); #1;
    bus.io_out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    tests++; if (bus.io_out_valid !== 1'b1) begin fails++; $display("FAIL mid_beat1_valid: got %b want 1", bus.io_out_valid); end
    @(posedge clock); #1;
    @(negedge clock);
    tests++; if (bus.io_out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", bus.io_out_valid); end
    tests++; if (pktCount !== 32'd0) begin fails++; $display("FAIL mid_rst_count: got %0d want 0", pktCount); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    tests++; if (beatQ.size() != 1) begin fails++; $display("FAIL mid_rst_beats: got %0d want 1", beatQ.size()); end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.io_out_ready = 1'b1;
    beatQ.delete(); beatCyc.delete();
    sendCmd(16'd10, 16'd64);
    idle(3);
    tests++;
    if (beatQ.size() != 1) begin
      fails++; $display("FAIL post_rst_beats: got %0d want 1", beatQ.size());
    end else begin
      tests++; if (beatQ[0].data !== hdrData(16'd10, 32'd0) || beatQ[0].last !== 1'b1) begin
        fails++; $display("FAIL post_rst_hdr: last=%b data=%h want seq 0", beatQ[0].last, beatQ[0].data); end
    end
    tests++; if (pktCount !== 32'd1) begin fails++; $display("FAIL post_rst_count: got %0d want 1", pktCount); end
  endtask

  initial begin
    bus.io_cmd_valid    = 1'b0;
    bus.io_cmd_bits_dst = '0;
    bus.io_cmd_bits_len = '0;
    bus.io_out_ready    = 1'b1;
    #1;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_back_to_back();
    test_zero_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
